fminmax_reduce: RTL

Streaming single-precision min/max reduction engine; the initiator-side consumer of the float compare path. It accepts a frame of IEEE-754 binary32 values over a valid/ready stream and returns the frame's min, max, their first-occurrence indices and the element count on a valid/ready result port. It sits between the operand sequencer and writeback for vector fmin/fmax reductions.

---
 rtl/fminmax_reduce.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fminmax_reduce.sv
// Streaming binary32 min/max reduction with first-occurrence indices and count.
// Optional IEEE minNum/maxNum NaN handling when FMINMAX_NAN_EN is defined.
module fminmax_reduce #(
    parameter int IDX_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_min_o,
    output logic [31:0]      out_max_o,
    output logic [IDX_W-1:0] out_min_idx_o,
    output logic [IDX_W-1:0] out_max_idx_o,
    output logic [IDX_W:0]   out_count_o,
    output logic             out_nan_o
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      min_q, min_d;
    logic [31:0]      max_q, max_d;
    logic [IDX_W-1:0] min_idx_q, min_idx_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             nan_q, nan_d;
    logic             have_q, have_d;

    logic             fire;
    logic             beat_nan;
    logic             beat_end;
    logic [IDX_W-1:0] beat_idx;
    logic [31:0]      key_in, key_min, key_max;
    logic             lt_min, gt_max;

    // Sign-magnitude to unsigned-orderable key.
    function automatic logic [31:0] fkey(input logic [31:0] v);
        return v[31] ? ~v : (v | 32'h8000_0000);
    endfunction

    assign fire     = in_valid_i && in_ready_o;
    assign beat_idx = (state_q == IDLE) ? '0 : count_q[IDX_W-1:0];
    assign beat_end = in_last_i || (beat_idx == '1);

    assign key_in  = fkey(in_data_i);
    assign key_min = fkey(min_q);
    assign key_max = fkey(max_q);
    assign lt_min  = key_in < key_min;
    assign gt_max  = key_in > key_max;

`ifdef FMINMAX_NAN_EN
    assign beat_nan = (in_data_i[30:23] == 8'hFF) && (in_data_i[22:0] != '0);
`else
    assign beat_nan = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = beat_end ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (fire && beat_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        unique case (state_q)
            IDLE:    in_ready_o  = 1'b1;
            ACCUM:   in_ready_o  = 1'b1;
            DONE:    out_valid_o = 1'b1;
            default: in_ready_o  = 1'b0;
        endcase
    end

    // A frame's first usable beat seeds both extremes; later beats compare.
    always_comb begin
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        count_d   = count_q;
        nan_d     = nan_q;
        have_d    = have_q;
        if (fire) begin
            if (state_q == IDLE) begin
                count_d   = (IDX_W+1)'(1);
                nan_d     = beat_nan;
                have_d    = !beat_nan;
                min_d     = beat_nan ? QNAN : in_data_i;
                max_d     = beat_nan ? QNAN : in_data_i;
                min_idx_d = '0;
                max_idx_d = '0;
            end else begin
                count_d = count_q + (IDX_W+1)'(1);
                if (beat_nan) begin
                    nan_d = 1'b1;
                end else if (!have_q) begin
                    have_d    = 1'b1;
                    min_d     = in_data_i;
                    max_d     = in_data_i;
                    min_idx_d = beat_idx;
                    max_idx_d = beat_idx;
                end else begin
                    if (lt_min) begin
                        min_d     = in_data_i;
                        min_idx_d = beat_idx;
                    end
                    if (gt_max) begin
                        max_d     = in_data_i;
                        max_idx_d = beat_idx;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
            nan_q     <= 1'b0;
            have_q    <= 1'b0;
        end else begin
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
            nan_q     <= nan_d;
            have_q    <= have_d;
        end
    end

    assign out_min_o     = min_q;
    assign out_max_o     = max_q;
    assign out_min_idx_o = min_idx_q;
    assign out_max_idx_o = max_idx_q;
    assign out_count_o   = count_q;
    assign out_nan_o     = nan_q;

endmodule
